lsu_mmio_ctrl: RTL and testbench
================================

// Module: lsu_mmio_ctrl
// PURPOSE
//  Multi-cycle load/store unit for the RV32I core with req/done handshake. Drives an external synchronous-read dmem.
//  Provides NUM_IO byte-maskable 32-bit MMIO output registers and a 2-flop-synchronised switch input.
//  Byte-lane alignment uses addr[1:0]. Misaligned, unmapped and illegal accesses are flagged and never written.
// PARAMETERS
//  DMEM_AW      11       dmem byte-address width; dmem region = addr[31:DMEM_AW]==0
//  NUM_IO       5        number of MMIO output registers (1..16)
//  IO_BASE_PG   20'h10000 page (addr[31:12]) of MMIO reg 0; reg k at IO_BASE_PG+k
//  SW_PG        20'h10010 page of read-only switch input
// PORTS
//  i_clk        in   1          clock
//  i_reset      in   1          async reset, active-low
//  i_req        in   1          access request, held until o_done
//  i_we         in   1          1=store, 0=load
//  i_funct3     in   3          RV32I load/store funct3
//  i_addr       in   32         byte address
//  i_st_data    in   32         store data (right-aligned)
//  o_done       out  1          1-cycle pulse: access complete
//  o_fault      out  1          valid with o_done: misaligned/unmapped/illegal
//  o_ld_data    out  32         extended load result, valid with o_done
//  o_dmem_addr  out  DMEM_AW-2  dmem word address
//  o_dmem_wdata out  32         lane-aligned store data
//  o_dmem_bmask out  4          byte write mask
//  o_dmem_wren  out  1          dmem write strobe
//  i_dmem_rdata in   32         dmem read word, valid 1 cycle after address
//  o_io_out     out  NUM_IO*32  MMIO regs, reg k at [32k+31:32k]
//  i_io_sw      in   32         async switch input
// BEHAVIOUR
//  Reset: FSM=IDLE; o_done, o_fault, o_ld_data, o_io_out, switch sync flops = 0; dmem strobes 0.
//  FSM IDLE/RD_WAIT/DONE. i_req is sampled only in IDLE; DONE always returns to IDLE.
//  IDLE+req, dmem load  -> RD_WAIT (addr driven) -> DONE (rdata captured). o_done 2 cycles after accept.
//  IDLE+req, other      -> DONE. o_done 1 cycle after accept.
//  Store: write committed at the accepting edge. o_dmem_wren is combinational in IDLE&req&we&legal&dmem.
//  Offset off=addr[1:0].
//   SB: mask 0001<<off, data {4{b}}. SH: mask 0011<<off, data {2{h}}. SW: 1111.
//  Load: word>>(8*off), then LB/LH sign-extend, LBU/LHU zero-extend, LW as is.
//  Misaligned: half with off[0]=1; word with off!=0 -> fault, no write, o_ld_data=0.
//  Illegal funct3: load 011/110/111; store >=011 -> fault, no write.
//  Unmapped page, or store to SW_PG -> fault, no write, load data 0.
//  MMIO read returns register value. SW_PG read returns the 2nd sync stage.
//  o_ld_data and o_fault are registered; both hold their value until the next o_done.
//  Async reset mid-access aborts: no pending write, no o_done.
// TESTING
//  SW 0xDEADBEEF to 0x10000000; LW back -> o_io_out[31:0]=DEADBEEF, ld=DEADBEEF, o_done 1 cyc after req.
//  SB 0x..A5 @0x00000003 -> bmask=1000, wdata=A5A5A5A5; LB @3 -> ld=FFFFFFA5; LBU -> 000000A5; done at 2 cyc.
//  SH @0x00000002 then LHU @2 -> bmask=1100, ld=0000xxxx zero-extended; LH with bit15=1 -> sign-ext.
//  LW @0x00000002 and SH @0x10001001 -> o_fault=1, no wren, register unchanged, ld=0.
//  i_io_sw=0x12345678 -> LW @0x10010000 returns it once 2 sync cycles elapse; SW there -> fault.
//  Assert i_reset low in RD_WAIT -> no o_done, all outputs 0; next req after release completes normally.

Source files
------------

// File: rtl/lsu_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mmio_ctrl
// Brief   : Multi-cycle RV32I load/store unit with req/done handshake. Drives
//           a synchronous-read data memory, owns NUM_IO byte-maskable MMIO
//           output registers and a two-flop synchronised switch input.
//           Misaligned, unmapped and illegal accesses fault and never write.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mmio_ctrl #(
    parameter int          DMEM_AW    = 11,
    parameter int          NUM_IO     = 5,
    parameter logic [19:0] IO_BASE_PG = 20'h10000,
    parameter logic [19:0] SW_PG      = 20'h10010
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_req,
    input  logic                   i_we,
    input  logic [2:0]             i_funct3,
    input  logic [31:0]            i_addr,
    input  logic [31:0]            i_st_data,
    output logic                   o_done,
    output logic                   o_fault,
    output logic [31:0]            o_ld_data,
    output logic [DMEM_AW-3:0]     o_dmem_addr,
    output logic [31:0]            o_dmem_wdata,
    output logic [3:0]             o_dmem_bmask,
    output logic                   o_dmem_wren,
    input  logic [31:0]            i_dmem_rdata,
    output logic [NUM_IO*32-1:0]   o_io_out,
    input  logic [31:0]            i_io_sw
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_WAIT = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_fault;
    logic [31:0] r_ld_data;
    logic [31:0] r_sw_s1;
    logic [31:0] r_sw_s2;
    logic [31:0] r_io [NUM_IO];

    logic [1:0]  w_off;
    logic [19:0] w_page;
    logic [19:0] w_io_diff;
    logic        w_is_dmem;
    logic        w_is_io;
    logic        w_is_sw;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_unmapped;
    logic        w_fault;
    logic        w_accept;
    logic        w_dmem_load;
    logic        w_st_ok;
    logic        w_io_wr;
    logic [3:0]  w_bmask;
    logic [31:0] w_wdata;
    logic [31:0] w_io_rd;
    logic [31:0] w_rd_src;

    // Align a fetched word to the accessed byte lane and apply the
    // sign/zero extension selected by the load funct3.
    function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  f_load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  f_load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b010:  f_load_ext = sh;
            3'b100:  f_load_ext = {24'd0, sh[7:0]};
            3'b101:  f_load_ext = {16'd0, sh[15:0]};
            default: f_load_ext = 32'd0;
        endcase
    endfunction

    assign w_off     = i_addr[1:0];
    assign w_page    = i_addr[31:12];
    assign w_is_dmem = (i_addr[31:DMEM_AW] == '0);
    // Pages below the base wrap to large values, so one compare bounds both sides.
    assign w_io_diff = w_page - IO_BASE_PG;
    assign w_is_io   = (w_io_diff < 20'(NUM_IO));
    assign w_is_sw   = (w_page == SW_PG);

    // Classify the presented access: legality, alignment and address map.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_unmapped   = 1'b0;
        if (i_we) begin
            w_illegal  = i_funct3[2] | (i_funct3[1:0] == 2'b11);
            w_unmapped = ~(w_is_dmem | w_is_io);
        end else begin
            w_illegal  = (i_funct3 == 3'b011) | (i_funct3[2:1] == 2'b11);
            w_unmapped = ~(w_is_dmem | w_is_io | w_is_sw);
        end
        w_misaligned = ((i_funct3[1:0] == 2'b01) & w_off[0]) |
                       ((i_funct3[1:0] == 2'b10) & (w_off != 2'b00));
        w_fault      = w_illegal | w_misaligned | w_unmapped;
    end

    assign w_accept    = (r_state == c_IDLE) & i_req;
    assign w_dmem_load = ~i_we & ~w_fault & w_is_dmem;
    assign w_st_ok     = i_we & ~w_fault;
    // dmem takes precedence should the two regions ever be configured to overlap.
    assign w_io_wr     = w_accept & w_st_ok & ~w_is_dmem & w_is_io;

    // Replicate store data across lanes and build the byte mask from the offset.
    always_comb begin
        w_bmask = 4'b1111;
        w_wdata = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                w_bmask = 4'b0001 << w_off;
                w_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                w_bmask = 4'b0011 << w_off;
                w_wdata = {2{i_st_data[15:0]}};
            end
            default: begin
                w_bmask = 4'b1111;
                w_wdata = i_st_data;
            end
        endcase
    end

    // Select the MMIO register addressed by the current page.
    always_comb begin
        w_io_rd = 32'd0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (w_io_diff == 20'(k)) begin
                w_io_rd = r_io[k];
            end
        end
    end

    assign w_rd_src = w_is_sw ? r_sw_s2 : w_io_rd;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: only dmem loads need the extra read-latency cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (i_req) begin
                    w_state_nxt = w_dmem_load ? c_RD_WAIT : c_DONE;
                end
            end
            c_RD_WAIT: w_state_nxt = c_DONE;
            c_DONE:    w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // FSM outputs: done pulse and the dmem write strobe (held off while in reset).
    always_comb begin
        o_done       = (r_state == c_DONE);
        o_dmem_wren  = w_accept & w_st_ok & w_is_dmem & i_reset;
        o_dmem_bmask = o_dmem_wren ? w_bmask : 4'b0000;
        o_dmem_wdata = w_wdata;
        o_dmem_addr  = i_addr[DMEM_AW-1:2];
    end

    // Result registers: loaded on the edge that enters DONE, held until the next one.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_off     <= 2'd0;
            r_funct3  <= 3'd0;
            r_fault   <= 1'b0;
            r_ld_data <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_req) begin
                        r_off    <= w_off;
                        r_funct3 <= i_funct3;
                        if (!w_dmem_load) begin
                            r_fault   <= w_fault;
                            r_ld_data <= (w_fault | i_we) ? 32'd0
                                       : f_load_ext(w_rd_src, w_off, i_funct3);
                        end
                    end
                end
                c_RD_WAIT: begin
                    r_fault   <= 1'b0;
                    r_ld_data <= f_load_ext(i_dmem_rdata, r_off, r_funct3);
                end
                default: begin
                    r_fault   <= r_fault;
                    r_ld_data <= r_ld_data;
                end
            endcase
        end
    end

    assign o_fault   = r_fault;
    assign o_ld_data = r_ld_data;

    // MMIO output registers: byte-masked write committed at the accepting edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < NUM_IO; k++) begin
                r_io[k] <= 32'd0;
            end
        end else if (w_io_wr) begin
            for (int k = 0; k < NUM_IO; k++) begin
                if (w_io_diff == 20'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_bmask[b]) begin
                            r_io[k][8*b +: 8] <= w_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sw_s1 <= 32'd0;
            r_sw_s2 <= 32'd0;
        end else begin
            r_sw_s1 <= i_io_sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    generate
        for (genvar gk = 0; gk < NUM_IO; gk++) begin : g_io_out
            assign o_io_out[32*gk +: 32] = r_io[gk];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mmio_ctrl
// Brief   : Self-checking bench for lsu_mmio_ctrl with a byte-level reference
//           model of dmem, MMIO registers and the switch input.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lsu_mmio_ctrl;

    localparam int NIO = 5;

    logic           clk;
    logic           rst_n;
    logic           req;
    logic           we;
    logic [2:0]     f3;
    logic [31:0]    addr;
    logic [31:0]    st_data;
    logic           done;
    logic           fault;
    logic [31:0]    ld_data;
    logic [8:0]     dmem_addr;
    logic [31:0]    dmem_wdata;
    logic [3:0]     dmem_bmask;
    logic           dmem_wren;
    logic [31:0]    dmem_rdata;
    logic [NIO*32-1:0] io_out;
    logic [31:0]    io_sw;

    int checks = 0;
    int errors = 0;
    int wren_cnt = 0;

    logic [31:0] dev_mem [512] = '{default: 32'd0};
    logic [7:0]  ref_mem [2048];
    logic [31:0] ref_io  [NIO];
    logic [31:0] ref_sw;

    lsu_mmio_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req        (req),
        .i_we         (we),
        .i_funct3     (f3),
        .i_addr       (addr),
        .i_st_data    (st_data),
        .o_done       (done),
        .o_fault      (fault),
        .o_ld_data    (ld_data),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .o_dmem_bmask (dmem_bmask),
        .o_dmem_wren  (dmem_wren),
        .i_dmem_rdata (dmem_rdata),
        .o_io_out     (io_out),
        .i_io_sw      (io_sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory device.
    always @(posedge clk) begin
        if (dmem_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (dmem_bmask[b]) dev_mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
            end
        end
        dmem_rdata <= dev_mem[dmem_addr];
    end

    always @(posedge clk) begin
        if (dmem_wren) wren_cnt <= wren_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_io(input string tag);
        for (int k = 0; k < NIO; k++) begin
            chk($sformatf("%s io%0d", tag, k), io_out[32*k +: 32], ref_io[k]);
        end
    endtask

    // Reference model: address map and byte-wise access semantics.
    task automatic model(input bit m_we, input logic [2:0] m_f3, input logic [31:0] m_addr,
                         input logic [31:0] m_data, output bit e_fault,
                         output logic [31:0] e_ld, output int e_lat, output bit e_wr);
        int rgn, idx, nb;
        bit illegal, mis, unm;
        logic [31:0] val;
        logic [7:0]  bt;
        idx = 0;
        if (m_addr < 32'h800) rgn = 0;
        else if ((m_addr >> 12) >= 32'h10000 && (m_addr >> 12) < 32'h10000 + NIO) begin
            rgn = 1; idx = int'((m_addr >> 12) - 32'h10000);
        end else if ((m_addr >> 12) == 32'h10010) rgn = 2;
        else rgn = 3;
        nb = 1 << (m_f3 & 3'd3);
        illegal = m_we ? (m_f3 >= 3'd3) : (m_f3 == 3'd3 || m_f3 == 3'd6 || m_f3 == 3'd7);
        mis = !illegal && ((m_addr % nb) != 0);
        unm = (rgn == 3) || (m_we && rgn == 2);
        e_fault = illegal || mis || unm;
        e_lat = (!m_we && !e_fault && rgn == 0) ? 2 : 1;
        e_wr = m_we && !e_fault && rgn == 0;
        e_ld = 32'd0;
        if (!e_fault) begin
            if (m_we) begin
                for (int i = 0; i < nb; i++) begin
                    bt = m_data[8*i +: 8];
                    if (rgn == 0) ref_mem[m_addr + i] = bt;
                    else ref_io[idx][8*((m_addr % 4) + i) +: 8] = bt;
                end
            end else begin
                val = 32'd0;
                for (int i = 0; i < nb; i++) begin
                    if (rgn == 0) bt = ref_mem[m_addr + i];
                    else if (rgn == 1) bt = ref_io[idx][8*((m_addr % 4) + i) +: 8];
                    else bt = ref_sw[8*((m_addr % 4) + i) +: 8];
                    val[8*i +: 8] = bt;
                end
                if (m_f3 == 3'd0 && val[7])  val = val | 32'hFFFFFF00;
                if (m_f3 == 3'd1 && val[15]) val = val | 32'hFFFF0000;
                e_ld = val;
            end
        end
    endtask

    task automatic access(input bit a_we, input logic [2:0] a_f3, input logic [31:0] a_addr,
                          input logic [31:0] a_data, input string tag);
        bit e_fault, e_wr, got;
        logic [31:0] e_ld;
        int e_lat, cyc, wc0;
        model(a_we, a_f3, a_addr, a_data, e_fault, e_ld, e_lat, e_wr);
        @(negedge clk);
        wc0 = wren_cnt;
        req = 1'b1; we = a_we; f3 = a_f3; addr = a_addr; st_data = a_data;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        req = 1'b0;
        chk({tag, " latency"}, 32'(cyc), 32'(e_lat));
        chk({tag, " fault"}, {31'd0, fault}, {31'd0, e_fault});
        if (!a_we || e_fault) chk({tag, " ld"}, ld_data, e_ld);
        chk({tag, " wren"}, 32'(wren_cnt - wc0), e_wr ? 32'd1 : 32'd0);
        chk_io(tag);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
        chk({tag, " fault hold"}, {31'd0, fault}, {31'd0, e_fault});
        if (!a_we || e_fault) chk({tag, " ld hold"}, ld_data, e_ld);
    endtask

    task automatic set_sw(input logic [31:0] v);
        @(negedge clk);
        io_sw = v;
        ref_sw = v;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [2:0]  rf;
        bit          rw;
        int          sel, nd;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'd0;
        for (int k = 0; k < NIO; k++) ref_io[k] = 32'd0;
        ref_sw = 32'd0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; st_data = 32'd0;
        io_sw = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset fault", {31'd0, fault}, 32'd0);
        chk("reset ld", ld_data, 32'd0);
        chk("reset wren", {31'd0, dmem_wren}, 32'd0);
        chk_io("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed steps
        access(1'b1, 3'b010, 32'h10000000, 32'hDEADBEEF, "SW io0");
        access(1'b0, 3'b010, 32'h10000000, 32'd0,        "LW io0");
        access(1'b1, 3'b000, 32'h00000003, 32'h123456A5, "SB 3");
        access(1'b0, 3'b000, 32'h00000003, 32'd0,        "LB 3");
        access(1'b0, 3'b100, 32'h00000003, 32'd0,        "LBU 3");
        access(1'b1, 3'b001, 32'h00000002, 32'h00008123, "SH 2");
        access(1'b0, 3'b101, 32'h00000002, 32'd0,        "LHU 2");
        access(1'b0, 3'b001, 32'h00000002, 32'd0,        "LH 2");
        access(1'b0, 3'b010, 32'h00000000, 32'd0,        "LW 0");
        access(1'b0, 3'b010, 32'h00000002, 32'd0,        "LW mis");
        access(1'b1, 3'b001, 32'h10001001, 32'hFFFF,     "SH mis io1");
        access(1'b1, 3'b010, 32'h10004004, 32'hCAFEF00D, "SW io4 off4");
        access(1'b1, 3'b000, 32'h10005000, 32'h55,       "SB unmapped io5");
        access(1'b0, 3'b010, 32'h00000800, 32'd0,        "LW unmapped");
        access(1'b0, 3'b011, 32'h00000000, 32'd0,        "ld f3=3");
        access(1'b0, 3'b110, 32'h00000000, 32'd0,        "ld f3=6");
        access(1'b1, 3'b011, 32'h00000000, 32'h1,        "st f3=3");
        access(1'b1, 3'b100, 32'h00000004, 32'h1,        "st f3=4");
        set_sw(32'h12345678);
        access(1'b0, 3'b010, 32'h10010000, 32'd0,        "LW sw");
        access(1'b0, 3'b000, 32'h10010001, 32'd0,        "LB sw+1");
        access(1'b1, 3'b010, 32'h10010000, 32'h1,        "SW sw");

        // Randomised accesses
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 4)      ra = $urandom_range(0, 63);
            else if (sel <= 7) ra = 32'h10000000 + ($urandom_range(0, NIO - 1) << 12) + $urandom_range(0, 4095);
            else if (sel == 8) ra = 32'h10010000 + $urandom_range(0, 4095);
            else begin
                case ($urandom_range(0, 3))
                    0:       ra = 32'h00000800;
                    1:       ra = 32'h10005000;
                    2:       ra = 32'hFFFFFFFC;
                    default: ra = 32'h0FFFF000;
                endcase
            end
            if ($urandom_range(0, 3) != 0) ra[1:0] = ($urandom_range(0, 1) == 0) ? 2'b00 : {ra[1], 1'b0};
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rf = 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) == 1 ? 3'b100 : 3'b000);
            rw = ($urandom_range(0, 1) == 1);
            rd = $urandom;
            if ($urandom_range(0, 15) == 0) set_sw($urandom);
            access(rw, rf, ra, rd, $sformatf("rnd%0d", n));
        end

        // Reset while a dmem load waits for its read data
        @(negedge clk);
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h00000000;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NIO; k++) ref_io[k] = 32'd0;
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort fault", {31'd0, fault}, 32'd0);
        chk("abort ld", ld_data, 32'd0);
        chk("abort wren", {31'd0, dmem_wren}, 32'd0);
        chk_io("abort");
        nd = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("abort no done", 32'(nd), 32'd0);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        access(1'b0, 3'b010, 32'h00000000, 32'd0,        "post-reset LW");
        access(1'b1, 3'b001, 32'h10002002, 32'h0000BEEF, "post-reset SH io2");
        access(1'b0, 3'b001, 32'h10002002, 32'd0,        "post-reset LH io2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
